paddle_mouse_mux: RTL and testbench

- Multi-player paddle source arbiter/accumulator in clk_sys domain, between hps_io outputs and the console core paddle inputs.
- Per player: either passes analog stick axes through, or integrates PS/2 mouse deltas into a held position with clamping, saturation or wrap, and idle timeout.
- Replaces the single-player inline mouse-emulation logic; sized by PLAYERS and output width.

---
 rtl/paddle_pkg.sv | 35 +++
 rtl/paddle_axis.sv | 50 +++++
 rtl/paddle_mouse_mux.sv | 148 ++++++++++++++
 tb/tb_paddle_mouse_mux.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types, ps2_mouse field positions and the saturating/wrapping
// accumulator step used by the paddle mouse multiplexer.
package paddle_pkg;

    typedef enum logic {
        SRC_ANALOG = 1'b0,
        SRC_MOUSE  = 1'b1
    } src_t;

    localparam int PS2_STROBE  = 24;
    localparam int PS2_DY_LSB  = 16;
    localparam int PS2_DX_LSB  = 8;
    localparam int PS2_YSIGN   = 5;
    localparam int PS2_XSIGN   = 4;
    localparam int PS2_BTN_LSB = 0;

    // Sum is formed at full int width, wide enough for any OUT_W below 31.
    function automatic int sat_add(input int pos, input int d, input logic wrap, input int out_w);
        int lo;
        int hi;
        int sum;
        lo  = -(1 << (out_w - 1));
        hi  = (1 << (out_w - 1)) - 1;
        sum = pos + d;
        if (wrap)
            return ((sum - lo) & ((1 << out_w) - 1)) + lo;
        else if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        else
            return sum;
    endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle axis: scales and clamps a PS/2 delta and integrates it into a
// held position; exposes the next position so the top can register outputs.
module paddle_axis
    import paddle_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter int DIV_SHIFT = 1,
    parameter int DELTA_MAX = 10
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    step,
    input  logic                    sign,
    input  logic [7:0]              mag,
    input  logic                    wrap_en,
    input  logic                    clear,
    input  logic                    recenter,
    output logic signed [OUT_W-1:0] pos_next
);

    logic signed [OUT_W-1:0] pos;
    logic signed [8:0]       raw;
    logic signed [8:0]       shifted;
    int                      delta;

    // Analog override and recenter both beat a mouse step on the same cycle.
    always_comb begin
        raw     = {sign, mag};
        shifted = raw >>> DIV_SHIFT;
        delta   = int'(shifted);
        if (delta > DELTA_MAX)
            delta = DELTA_MAX;
        else if (delta < -DELTA_MAX)
            delta = -DELTA_MAX;

        pos_next = pos;
        if (clear || recenter)
            pos_next = '0;
        else if (step)
            pos_next = OUT_W'(sat_add(int'(pos), delta, wrap_en, OUT_W));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            pos <= '0;
        else
            pos <= pos_next;
    end

endmodule

// File: rtl/paddle_mouse_mux.sv
// Per-player paddle source selection: analog stick passthrough or PS/2 mouse
// integration, with optional idle timeout back to the analog source.
module paddle_mouse_mux
    import paddle_pkg::*;
#(
    parameter int PLAYERS     = 2,
    parameter int OUT_W       = 8,
    parameter int DIV_SHIFT   = 1,
    parameter int DELTA_MAX   = 10,
    parameter int IDLE_CYCLES = 0,
    localparam int SEL_W      = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [24:0]              ps2_mouse,
    input  logic [SEL_W-1:0]         mouse_sel,
    input  logic [PLAYERS*16-1:0]    joya,
    input  logic [PLAYERS*2-1:0]     joy_btn,
    input  logic                     recenter,
    input  logic                     wrap_en,
    output logic [PLAYERS*OUT_W-1:0] paddle_x,
    output logic [PLAYERS*OUT_W-1:0] paddle_y,
    output logic [PLAYERS*2-1:0]     btn_out,
    output logic [PLAYERS-1:0]       mouse_active
);

    localparam int CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;

    logic strobe_hist;
    logic hist_valid;
    logic event_seen;
    logic unused_bits;

    assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

    // hist_valid keeps a strobe level already toggled at reset release from
    // being mistaken for a fresh mouse packet.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            strobe_hist <= 1'b0;
            hist_valid  <= 1'b0;
        end else begin
            strobe_hist <= ps2_mouse[PS2_STROBE];
            hist_valid  <= 1'b1;
        end
    end

    assign event_seen = hist_valid && (ps2_mouse[PS2_STROBE] != strobe_hist);

    for (genvar i = 0; i < PLAYERS; i++) begin : g_player
        src_t                    state;
        src_t                    state_next;
        logic [CNT_W-1:0]        idle_cnt;
        logic [CNT_W-1:0]        idle_cnt_next;
        logic [1:0]              mbtn;
        logic [1:0]              mbtn_next;
        logic                    hit;
        logic                    analog_nz;
        logic [7:0]              joy_x;
        logic [7:0]              joy_y;
        logic signed [OUT_W-1:0] pos_x_next;
        logic signed [OUT_W-1:0] pos_y_next;
        logic [OUT_W-1:0]        out_x;
        logic [OUT_W-1:0]        out_y;
        logic [1:0]              out_btn;

        assign joy_x     = joya[i*16 +: 8];
        assign joy_y     = joya[i*16+8 +: 8];
        assign analog_nz = (joya[i*16 +: 16] != 16'd0);
        assign hit       = event_seen && (mouse_sel == SEL_W'(i));

        paddle_axis #(.OUT_W(OUT_W), .DIV_SHIFT(DIV_SHIFT), .DELTA_MAX(DELTA_MAX)) u_axis_x (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .step     (hit),
            .sign     (ps2_mouse[PS2_XSIGN]),
            .mag      (ps2_mouse[PS2_DX_LSB +: 8]),
            .wrap_en  (wrap_en),
            .clear    (analog_nz),
            .recenter (recenter),
            .pos_next (pos_x_next)
        );

        paddle_axis #(.OUT_W(OUT_W), .DIV_SHIFT(DIV_SHIFT), .DELTA_MAX(DELTA_MAX)) u_axis_y (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .step     (hit),
            .sign     (ps2_mouse[PS2_YSIGN]),
            .mag      (ps2_mouse[PS2_DY_LSB +: 8]),
            .wrap_en  (wrap_en),
            .clear    (analog_nz),
            .recenter (recenter),
            .pos_next (pos_y_next)
        );

        // Any stick movement reclaims the player before a mouse event can.
        always_comb begin
            state_next    = state;
            idle_cnt_next = idle_cnt;
            mbtn_next     = mbtn;
            if (analog_nz) begin
                state_next    = SRC_ANALOG;
                idle_cnt_next = '0;
            end else if (hit) begin
                state_next    = SRC_MOUSE;
                idle_cnt_next = '0;
                mbtn_next     = ps2_mouse[PS2_BTN_LSB +: 2];
            end else if (state == SRC_MOUSE && IDLE_CYCLES > 0) begin
                if (int'(idle_cnt) + 1 >= IDLE_CYCLES) begin
                    state_next    = SRC_ANALOG;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                state    <= SRC_ANALOG;
                idle_cnt <= '0;
                mbtn     <= '0;
                out_x    <= '0;
                out_y    <= '0;
                out_btn  <= '0;
            end else begin
                state    <= state_next;
                idle_cnt <= idle_cnt_next;
                mbtn     <= mbtn_next;
                if (state_next == SRC_MOUSE) begin
                    out_x   <= pos_x_next;
                    out_y   <= pos_y_next;
                    out_btn <= mbtn_next;
                end else begin
                    out_x   <= OUT_W'($signed(joy_x));
                    out_y   <= OUT_W'($signed(joy_y));
                    out_btn <= joy_btn[i*2 +: 2];
                end
            end
        end

        assign paddle_x[i*OUT_W +: OUT_W] = out_x;
        assign paddle_y[i*OUT_W +: OUT_W] = out_y;
        assign btn_out[i*2 +: 2]          = out_btn;
        assign mouse_active[i]            = (state == SRC_MOUSE);
    end

endmodule

// File: tb/tb_paddle_mouse_mux.sv
// Scoreboard bench for paddle_mouse_mux: dut_a uses default parameters,
// dut_b has three players and a 16-cycle idle timeout.
module tb_paddle_mouse_mux;

    localparam int K_X   = 0;
    localparam int K_Y   = 1;
    localparam int K_BTN = 2;
    localparam int K_ACT = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] ps2_mouse = '0;
    logic [1:0]  mouse_sel = '0;
    logic [47:0] joya = '0;
    logic [5:0]  joy_btn = '0;
    logic        recenter = 1'b0;
    logic        wrap_en = 1'b0;

    logic [15:0] ax, ay;
    logic [3:0]  abtn;
    logic [1:0]  aact;
    logic [23:0] bx, by;
    logic [5:0]  bbtn;
    logic [2:0]  bact;

    typedef struct {
        int    tag;
        int    dut;
        int    player;
        int    kind;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk_sys = ~clk_sys;

    paddle_mouse_mux dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse),
        .mouse_sel(mouse_sel[0]), .joya(joya[31:0]), .joy_btn(joy_btn[3:0]),
        .recenter(recenter), .wrap_en(wrap_en),
        .paddle_x(ax), .paddle_y(ay), .btn_out(abtn), .mouse_active(aact)
    );

    paddle_mouse_mux #(.PLAYERS(3), .IDLE_CYCLES(16)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse),
        .mouse_sel(mouse_sel), .joya(joya), .joy_btn(joy_btn),
        .recenter(recenter), .wrap_en(wrap_en),
        .paddle_x(bx), .paddle_y(by), .btn_out(bbtn), .mouse_active(bact)
    );

    function automatic int get_out(input int d, input int p, input int k);
        if (d == 0) begin
            case (k)
                K_X:     return int'($signed(ax[p*8 +: 8]));
                K_Y:     return int'($signed(ay[p*8 +: 8]));
                K_BTN:   return int'(abtn[p*2 +: 2]);
                default: return int'(aact[p]);
            endcase
        end else begin
            case (k)
                K_X:     return int'($signed(bx[p*8 +: 8]));
                K_Y:     return int'($signed(by[p*8 +: 8]));
                K_BTN:   return int'(bbtn[p*2 +: 2]);
                default: return int'(bact[p]);
            endcase
        end
    endfunction

    // Monitor: outputs settle 1 time unit after the edge that produced them.
    always @(posedge clk_sys) begin
        chk_t e;
        int   act;
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e   = sb.pop_front();
            act = get_out(e.dut, e.player, e.kind);
            tests = tests + 1;
            if (act != e.exp) begin
                failed = failed + 1;
                $display("[TB] FAIL %s: actual %0d required %0d", e.name, act, e.exp);
            end
        end
    end

    // Expectation for the outputs registered at the coming clock edge.
    task automatic checkOutput(input int d, input int p, input int k, input int exp, input string name);
        chk_t e;
        e.tag = cyc + 1; e.dut = d; e.player = p; e.kind = k; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input bit evt);
        if (evt) ps2_mouse[24] = ~ps2_mouse[24];
        @(negedge clk_sys);
    endtask

    task automatic set_mouse(input logic [1:0] sel, input logic xs, input logic [7:0] dx,
                             input logic ys, input logic [7:0] dy, input logic [1:0] btn);
        mouse_sel           = sel;
        ps2_mouse[4]        = xs;
        ps2_mouse[15:8]     = dx;
        ps2_mouse[5]        = ys;
        ps2_mouse[23:16]    = dy;
        ps2_mouse[1:0]      = btn;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        applyStimulus(0);
        applyStimulus(0);
        reset_n = 1'b1;
        applyStimulus(0);
    endtask

    initial begin
        @(negedge clk_sys);

        // 1: strobe toggles under reset, then a stale toggle at release
        set_mouse(2'd0, 1'b0, 8'h40, 1'b0, 8'h00, 2'b00);
        checkOutput(0, 0, K_ACT, 0, "rst_act0");
        checkOutput(0, 0, K_X, 0, "rst_x0");
        applyStimulus(1);
        checkOutput(0, 1, K_ACT, 0, "rst_act1");
        checkOutput(1, 0, K_BTN, 0, "rst_b_btn0");
        applyStimulus(1);
        applyStimulus(1);
        reset_n = 1'b1;
        checkOutput(0, 0, K_ACT, 0, "release_first_clk");
        applyStimulus(0);
        checkOutput(0, 0, K_ACT, 0, "release_steady");
        checkOutput(0, 0, K_X, 0, "release_x");
        applyStimulus(0);

        // 2: +10 per event saturates at 127, then wraps to -126
        do_reset();
        set_mouse(2'd0, 1'b0, 8'h40, 1'b0, 8'h04, 2'b01);
        for (int i = 1; i <= 13; i++) begin
            checkOutput(0, 0, K_X, (10 * i > 127) ? 127 : 10 * i, "sat_x");
            checkOutput(0, 0, K_ACT, 1, "sat_act");
            if (i == 13) begin
                checkOutput(0, 0, K_Y, 26, "sat_y");
                checkOutput(0, 0, K_BTN, 1, "mouse_btn");
                checkOutput(0, 1, K_X, 0, "p1_untouched");
            end
            applyStimulus(1);
        end
        checkOutput(0, 0, K_X, 127, "sat_hold");
        applyStimulus(0);
        do_reset();
        for (int i = 1; i <= 12; i++) applyStimulus(1);
        wrap_en = 1'b1;
        checkOutput(0, 0, K_X, -126, "wrap_x");
        applyStimulus(1);
        wrap_en = 1'b0;

        // 3: player 1 negative saturation; player 0 held at 20
        do_reset();
        set_mouse(2'd0, 1'b0, 8'h40, 1'b0, 8'h00, 2'b00);
        applyStimulus(1);
        applyStimulus(1);
        set_mouse(2'd1, 1'b1, 8'hF0, 1'b0, 8'h00, 2'b00);
        for (int i = 1; i <= 17; i++) begin
            checkOutput(0, 1, K_X, (i >= 16) ? -128 : -8 * i, "neg_x");
            checkOutput(0, 0, K_X, 20, "p0_held_x");
            checkOutput(0, 0, K_ACT, 1, "p0_held_act");
            applyStimulus(1);
        end

        // 4: analog takeover clears the accumulated position
        do_reset();
        set_mouse(2'd0, 1'b0, 8'h40, 1'b0, 8'h00, 2'b00);
        for (int i = 1; i <= 4; i++) applyStimulus(1);
        joya[15:0] = 16'h0005;
        joy_btn[1:0] = 2'b10;
        checkOutput(0, 0, K_ACT, 0, "analog_act");
        checkOutput(0, 0, K_X, 5, "analog_x");
        checkOutput(0, 0, K_BTN, 2, "analog_btn");
        applyStimulus(0);
        joya[15:0] = 16'h0000;
        checkOutput(0, 0, K_X, 0, "analog_zero_x");
        applyStimulus(0);
        checkOutput(0, 0, K_X, 10, "pos_cleared_x");
        checkOutput(0, 0, K_ACT, 1, "reentry_act");
        applyStimulus(1);
        joya[15:0] = 16'h0300;
        checkOutput(0, 0, K_ACT, 0, "analog_wins_act");
        checkOutput(0, 0, K_Y, 3, "analog_wins_y");
        checkOutput(0, 0, K_X, 0, "analog_wins_x");
        applyStimulus(1);
        joya[15:0] = 16'h0000;
        applyStimulus(0);
        checkOutput(0, 0, K_X, 10, "after_win_x");
        applyStimulus(1);
        joy_btn = '0;

        // 5: idle timeout on dut_b, position retained, count restart
        do_reset();
        set_mouse(2'd0, 1'b0, 8'h40, 1'b0, 8'h00, 2'b00);
        checkOutput(1, 0, K_X, 10, "idle_first_x");
        applyStimulus(1);
        for (int k = 1; k <= 16; k++) begin
            if (k == 15) checkOutput(1, 0, K_ACT, 1, "idle15_act");
            if (k == 16) begin
                checkOutput(1, 0, K_ACT, 0, "idle16_act");
                checkOutput(1, 0, K_X, 0, "idle16_x");
            end
            applyStimulus(0);
        end
        checkOutput(1, 0, K_X, 20, "idle_retained_x");
        checkOutput(1, 0, K_ACT, 1, "idle_reentry_act");
        applyStimulus(1);
        for (int k = 1; k <= 14; k++) applyStimulus(0);
        checkOutput(1, 0, K_X, 30, "restart_x");
        applyStimulus(1);
        for (int k = 1; k <= 16; k++) begin
            if (k == 15) checkOutput(1, 0, K_ACT, 1, "restart15_act");
            if (k == 16) checkOutput(1, 0, K_ACT, 0, "restart16_act");
            applyStimulus(0);
        end

        // 6: out-of-range select on dut_b; recenter beside an event on dut_a
        do_reset();
        set_mouse(2'd3, 1'b0, 8'h40, 1'b0, 8'h00, 2'b00);
        for (int p = 0; p < 3; p++) checkOutput(1, p, K_ACT, 0, "bad_sel_act");
        checkOutput(1, 0, K_X, 0, "bad_sel_x");
        applyStimulus(1);
        do_reset();
        set_mouse(2'd0, 1'b0, 8'h40, 1'b0, 8'h00, 2'b00);
        for (int i = 1; i <= 3; i++) applyStimulus(1);
        recenter = 1'b1;
        checkOutput(0, 0, K_X, 0, "recenter_x");
        checkOutput(0, 0, K_ACT, 1, "recenter_act");
        applyStimulus(1);
        recenter = 1'b0;
        checkOutput(0, 0, K_X, 10, "post_recenter_x");
        applyStimulus(1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) applyStimulus(0);
        if (sb.size() != 0) begin
            tests = tests + 1;
            failed = failed + 1;
            $display("[TB] FAIL drain: actual %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
